// File: rtl/arm_defs.sv
// Shared encodings for the ARM conditional-execution path:
// condition codes, NZCV bit positions and flag-write group masks.
package arm_defs;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] FLAGW_NZ = 2'b10;
  localparam logic [1:0] FLAGW_CV = 2'b01;

endpackage

// File: rtl/cond_logic_cond_check.sv
// Combinational condition evaluator: Cond field against
// the registered NZCV flags.
module cond_check
  import arm_defs::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex,
  output logic       condinvalid
);

  logic n, z, c, v, ge;

  assign n  = flags[FLAG_N];
  assign z  = flags[FLAG_Z];
  assign c  = flags[FLAG_C];
  assign v  = flags[FLAG_V];
  assign ge = (n == v);

  always_comb begin
    condex      = 1'b0;
    condinvalid = 1'b0;
    case (cond)
      COND_EQ: condex = z;
      COND_NE: condex = ~z;
      COND_CS: condex = c;
      COND_CC: condex = ~c;
      COND_MI: condex = n;
      COND_PL: condex = ~n;
      COND_VS: condex = v;
      COND_VC: condex = ~v;
      COND_HI: condex = c & ~z;
      COND_LS: condex = ~c | z;
      COND_GE: condex = ge;
      COND_LT: condex = ~ge;
      COND_GT: condex = ~z & ge;
      COND_LE: condex = z | ~ge;
      COND_AL: condex = 1'b1;
      COND_NV: condinvalid = 1'b1;
      default: begin
        condex      = 1'b0;
        condinvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: NZCV flag registers,
// condition check and gating of decoder write strobes.
module cond_logic
  import arm_defs::*;
#(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       En,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic       CondInvalid,
  output logic [3:0] Flags
);

  logic [1:0] nz_q;
  logic [1:0] cv_q;
  logic       go;
  logic       nz_we;
  logic       cv_we;

  assign Flags = {nz_q, cv_q};

  cond_check u_check (
    .cond        (Cond),
    .flags       (Flags),
    .condex      (CondEx),
    .condinvalid (CondInvalid)
  );

  assign go    = En & CondEx;
  assign nz_we = go & |(FlagW & FLAGW_NZ);
  assign cv_we = go & |(FlagW & FLAGW_CV);

  assign PCSrc    = PCS & go;
  assign RegWrite = RegW & go & ~NoWrite;
  assign MemWrite = MemW & go;

  // Groups update independently so logic ops can keep C/V.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nz_q <= FLAG_RESET[3:2];
      cv_q <= FLAG_RESET[1:0];
    end else begin
      if (nz_we) nz_q <= ALUFlags[3:2];
      if (cv_we) cv_q <= ALUFlags[1:0];
    end
  end

endmodule

// File: tb/tb_cond_logic.sv
// Directed self-checking bench for cond_logic: reset, flag
// groups, strobe gating, stall and a full Cond x Flags sweep.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic       En;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite;
  logic       PCSrc, RegWrite, MemWrite;
  logic       CondEx, CondInvalid;
  logic [3:0] Flags;

  int checks = 0;
  int errors = 0;

  cond_logic #(.FLAG_RESET(4'b0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .En          (En),
    .Cond        (Cond),
    .ALUFlags    (ALUFlags),
    .FlagW       (FlagW),
    .PCS         (PCS),
    .RegW        (RegW),
    .MemW        (MemW),
    .NoWrite     (NoWrite),
    .PCSrc       (PCSrc),
    .RegWrite    (RegWrite),
    .MemWrite    (MemWrite),
    .CondEx      (CondEx),
    .CondInvalid (CondInvalid),
    .Flags       (Flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference table, written as the architectural truth table.
  function automatic logic ref_cond(input logic [3:0] c,
                                    input logic [3:0] f);
    logic n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cc;
      4'd3:  return !cc;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cc && !z;
      4'd9:  return !cc || z;
      4'd10: return n ~^ v;
      4'd11: return n ^ v;
      4'd12: return !z && (n ~^ v);
      4'd13: return z || (n ^ v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic load_flags(input logic [3:0] f);
    En = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
    PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
    tick();
    FlagW = 2'b00;
  endtask

  initial begin
    reset = 1; En = 0; Cond = 4'b1110; ALUFlags = 0;
    FlagW = 0; PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
    tick(); tick();
    chk("reset_flags", Flags, 4'b0000);
    reset = 0;

    load_flags(4'b1111);
    chk("load_1111", Flags, 4'b1111);
    FlagW = 2'b11; ALUFlags = 4'b1111;
    #3 reset = 1;
    #1 chk("async_reset", Flags, 4'b0000);
    tick();
    chk("reset_discards_write", Flags, 4'b0000);
    reset = 0; FlagW = 0;

    Cond = 4'b0000;
    #1 chk("eq_after_reset", {3'b0, CondEx}, 4'd0);
    Cond = 4'b1110; RegW = 1; En = 1;
    #1 chk("al_regwrite", {3'b0, RegWrite}, 4'd1);
    RegW = 0;

    load_flags(4'b0110);
    chk("subs_flags", Flags, 4'b0110);
    Cond = 4'b0000; MemW = 1;
    #1 chk("eq_memwrite", {3'b0, MemWrite}, 4'd1);
    Cond = 4'b0001;
    #1 chk("ne_memwrite", {3'b0, MemWrite}, 4'd0);
    MemW = 0;

    Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b1000;
    tick();
    chk("nz_only", Flags, 4'b1010);
    FlagW = 2'b01; ALUFlags = 4'b0101;
    tick();
    chk("cv_only", Flags, 4'b1001);
    FlagW = 0;

    load_flags(4'b0000);
    Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b1111;
    PCS = 1; RegW = 1; MemW = 1;
    #1 chk("fail_strobes", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
    tick();
    chk("fail_no_flag", Flags, 4'b0000);

    Cond = 4'b1110; FlagW = 0; PCS = 0; MemW = 0; RegW = 1; NoWrite = 1;
    #1 chk("cmp_nowrite", {3'b0, RegWrite}, 4'd0);
    NoWrite = 0;

    En = 0; FlagW = 2'b11; ALUFlags = 4'b1001;
    PCS = 1; RegW = 1; MemW = 1;
    #1 chk("stall_strobes", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
    chk("stall_condex", {3'b0, CondEx}, 4'd1);
    tick();
    chk("stall_flags", Flags, 4'b0000);
    En = 1; FlagW = 0;

    Cond = 4'b1111;
    #1 chk("nv_invalid", {2'b0, CondInvalid, CondEx}, 4'b0010);
    chk("nv_strobes", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
    PCS = 0; RegW = 0; MemW = 0;

    for (int f = 0; f < 16; f++) begin
      load_flags(4'(f));
      chk("sweep_load", Flags, 4'(f));
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c);
        #1 chk($sformatf("sweep_c%0d_f%0d", c, f), {3'b0, CondEx},
               {3'b0, ref_cond(4'(c), 4'(f))});
        chk($sformatf("inv_c%0d_f%0d", c, f), {3'b0, CondInvalid},
            (c == 15) ? 4'd1 : 4'd0);
      end
    end

    load_flags(4'b1001);
    Cond = 4'b1100;
    #1 chk("gt_1001", {3'b0, CondEx}, 4'd1);
    Cond = 4'b1101;
    #1 chk("le_1001", {3'b0, CondEx}, 4'd0);
    load_flags(4'b0100);
    Cond = 4'b1100;
    #1 chk("gt_0100", {3'b0, CondEx}, 4'd0);
    Cond = 4'b1101;
    #1 chk("le_0100", {3'b0, CondEx}, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Conditional-execution unit of the single-cycle ARM datapath. It sits directly downstream of the 32-bit ALU and consumes its 4-bit ALUFlags output.
- Holds the architectural NZCV flags and evaluates the instruction's Cond field against them.
- Gates the decoder's write strobes (PCS, RegW, MemW) so only instructions whose condition passes change architectural state.
- Flag updates are conditional and split into NZ and CV groups.

Parameters:
- FLAG_RESET, 4'b0000, NZCV value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- En  input  1  instruction-valid/advance; 0 = stall, no state change and all write strobes forced 0
- Cond  input  4  instruction bits [31:28]
- ALUFlags  input  4  {N,Z,C,V} from ALU for the current instruction
- FlagW  input  2  decoder flag-write request; [1] = NZ group, [0] = CV group
- PCS  input  1  decoder: instruction writes PC
- RegW  input  1  decoder: instruction writes register file
- MemW  input  1  decoder: instruction writes memory
- NoWrite  input  1  decoder: suppress register write (CMP/CMN/TST/TEQ)
- PCSrc  output  1  gated PC-write select
- RegWrite  output  1  gated register-file write enable
- MemWrite  output  1  gated data-memory write enable
- CondEx  output  1  condition passed for current instruction
- CondInvalid  output  1  Cond == 4'b1111 (unsupported encoding)
- Flags  output  4  current registered {N,Z,C,V}

Behaviour:
- Reset (async, active-high):
  - Flags <= FLAG_RESET immediately.
  - Combinational outputs follow from the reset flags and the current inputs.
  - Reset asserted mid-operation discards any pending flag write in that cycle.
- Condition evaluation is combinational on the registered Flags (N,Z,C,V = Flags[3:0]):
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: CondEx=0, CondInvalid=1
- Gated strobes (combinational, zero latency):
  - PCSrc = PCS & CondEx & En
  - RegWrite = RegW & CondEx & En & ~NoWrite
  - MemWrite = MemW & CondEx & En
- Flag register update at rising clk edge:
  - Flags[3:2] <= ALUFlags[3:2] iff En & CondEx & FlagW[1]
  - Flags[1:0] <= ALUFlags[1:0] iff En & CondEx & FlagW[0]
  - Otherwise each group holds its value. The two groups are independent.
- Ordering:
  - An instruction evaluates its condition against the flags that existed before it executed.
  - Its own flag update is visible only from the next cycle.
  - No bypass from ALUFlags to CondEx.
- Failed condition: no flag update and all strobes 0, even if FlagW is nonzero.
- En=0: Flags hold; PCSrc/RegWrite/MemWrite=0. CondEx and CondInvalid still reflect Cond and Flags.
- Interaction with ALU modes: the ALU forces C=V=0 for AND/ORR. The decoder issues FlagW=2'b10 for logic ops, so C/V are preserved. cond_logic does not inspect ALUCtrl.
- X-safety: Cond and FlagW decoding uses full-case with a defined default (CondEx=0). Flags never go X after reset.

Decomposition:
- Shared package/header `arm_defs`:
  - Cond encodings COND_EQ..COND_AL, COND_NV.
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FlagW group masks FLAGW_NZ=2'b10, FLAGW_CV=2'b01.
- One sub-module, `cond_check`: purely combinational (Cond, Flags) -> (CondEx, CondInvalid).
- Top level holds:
  - Two flag-group registers, each 2 bits with its own enable.
  - Strobe gating.

Test Plan:
- Reset, FLAG_RESET=0: assert reset mid-cycle -> Flags=0000 asynchronously. Cond=EQ -> CondEx=0. Cond=AL, RegW=1, En=1 -> RegWrite=1.
- SUBS equal operands: Cond=AL, FlagW=11, ALUFlags=0110, edge -> Flags=0110. Next cycle Cond=EQ, MemW=1 -> MemWrite=1. Cond=NE -> MemWrite=0.
- Group independence: Flags=0110; AND-type op Cond=AL, FlagW=10, ALUFlags=1000 -> Flags=1010 (C kept, Z cleared).
- Failed condition: Flags=0000, Cond=EQ, FlagW=11, ALUFlags=1111, PCS=RegW=MemW=1 -> all strobes 0; after edge Flags still 0000.
- CMP suppression and stall:
  - Cond=AL, RegW=1, NoWrite=1 -> RegWrite=0.
  - En=0, FlagW=11, ALUFlags=1001 -> Flags unchanged, strobes 0.
  - Cond=1111 -> CondInvalid=1, CondEx=0.
- Exhaustive condition sweep: all 16 Flags values × 16 Cond values against a reference table. Include GT/LE with Flags=1001 (N=V=1, Z=0) -> GT=1, LE=0; and Flags=0100 -> GT=0, LE=1.
